// File: rtl/rfifo_drain_arbiter.sv
// Read-side drain stage: round-robin pops from NUM_CH FWFT read FIFOs into a
// 2-entry output buffer, locking onto a channel until its burst's last beat.
module rfifo_drain_arbiter #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 32,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         AXI_clk,
   input  logic                         AXI_rst,
   input  logic [NUM_CH-1:0]            rempty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] rdata,
   input  logic [NUM_CH-1:0]            rlast_in,
   output logic [NUM_CH-1:0]            rinc,
   output logic [DATA_WIDTH-1:0]        read_data,
   output logic                         read_last,
   output logic [CH_W-1:0]              read_ch,
   output logic                         read_data_valid,
   input  logic                         read_data_ready,
   output logic [1:0]                   occupancy
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic [CH_W-1:0]       ch;
   } entry_t;

   entry_t          head_q, tail_q, push_e;
   logic [1:0]      count_q;
   logic            lock_q;
   logic [CH_W-1:0] lock_ch_q, rr_ptr_q, grant;
   logic            grant_vld, may_pop, pop, xfer;

   // Pop decision uses only registered count, never read_data_ready.
   assign may_pop = (count_q < 2'd2) & ~AXI_rst;
   assign pop     = may_pop & grant_vld;
   assign xfer    = read_data_valid & read_data_ready;

   // Unlocked: scan from rr_ptr upward; descending i so the closest match wins.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      if (lock_q) begin
         grant     = lock_ch_q;
         grant_vld = ~rempty[lock_ch_q];
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (c == (int'(rr_ptr_q) + i) % NUM_CH && !rempty[c]) begin
                  grant     = CH_W'(c);
                  grant_vld = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      push_e    = '0;
      push_e.ch = grant;
      rinc      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant == CH_W'(c)) begin
            push_e.data = rdata[c*DATA_WIDTH +: DATA_WIDTH];
            push_e.last = rlast_in[c];
            rinc[c]     = pop;
         end
      end
   end

   always_ff @(posedge AXI_clk or posedge AXI_rst) begin
      if (AXI_rst) begin
         count_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         count_q <= count_q + {1'b0, pop} - {1'b0, xfer};
         if (xfer && count_q == 2'd2)
            head_q <= tail_q;
         // A pop only happens with count<2, so a concurrent transfer implies count==1.
         if (pop) begin
            if (count_q == 2'd0 || xfer)
               head_q <= push_e;
            else
               tail_q <= push_e;
            if (push_e.last) begin
               lock_q   <= 1'b0;
               rr_ptr_q <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
            end else begin
               lock_q    <= 1'b1;
               lock_ch_q <= grant;
            end
         end
      end
   end

   assign read_data       = head_q.data;
   assign read_last       = head_q.last;
   assign read_ch         = head_q.ch;
   assign read_data_valid = (count_q != 2'd0);
   assign occupancy       = count_q;

endmodule
